regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port GPR file, successor to the single-write/two-read regfile.
//  - N combinational read ports, two write ports with fixed priority.
//  - Multi-cycle soft-clear sequencer (clear without asserting reset).
//  - Optional same-cycle write->read bypass.
//  Sits in ID: read ports feed operand fetch; write ports are driven by WB (port 0) and the early/MEM result path (port 1).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   register address width
//  NUM_REGS  32  number of registers; must be <= 2**ADDR_W
//  NUM_RD    2   number of read ports, >= 1
//  ZERO_REG  1   1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
// PORTS
//  clk       in   1              clock; all state updates on posedge
//  rst       in   1              asynchronous reset, active-low
//  clr_req   in   1              soft-clear request, sampled on posedge
//  clr_busy  out  1              soft clear in progress
//  we0       in   1              write enable, port 0
//  waddr0    in   ADDR_W         write address, port 0
//  wdata0    in   DATA_W         write data, port 0
//  we1       in   1              write enable, port 1 (higher priority)
//  waddr1    in   ADDR_W         write address, port 1
//  wdata1    in   DATA_W         write data, port 1
//  re        in   NUM_RD         per-port read enable
//  raddr     in   NUM_RD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
//  rdata     out  NUM_RD*DATA_W  read data; port k at [k*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset (rst=0, asynchronous): all registers 0; FSM IDLE; clr_idx 0; clr_busy 0; all rdata 0 while rst=0.
//  Write (posedge, FSM IDLE): port p writes if we_p=1, waddr_p<NUM_REGS, and not (ZERO_REG=1 and waddr_p=0).
//   - Both ports to same address: port 1 value stored.
//   - Different addresses: both stored in the same cycle.
//   - Addresses >= NUM_REGS: write ignored.
//  Read (combinational, per port k):
//   - rdata_k = 0 if re_k=0, rst=0, clr_busy=1, raddr_k>=NUM_REGS, or (ZERO_REG=1 and raddr_k=0).
//   - Otherwise rdata_k = stored value (or bypass value, see CONFIGURATION).
//  Soft-clear FSM, states IDLE / CLEAR:
//   - IDLE: clr_req=1 at posedge -> CLEAR, clr_idx=0; writes that same edge are still performed.
//   - CLEAR: each posedge zeroes regs[clr_idx] and increments clr_idx. At clr_idx=NUM_REGS-1 it zeroes the last register and returns to IDLE.
//   - clr_busy=1 exactly while in CLEAR, i.e. NUM_REGS cycles.
//   - In CLEAR, we0/we1 are dropped (not queued); the pipeline stalls on clr_busy.
//   - clr_req while in CLEAR is ignored (no restart, no extension).
//  Reset mid-clear: FSM to IDLE, clr_busy 0, all registers 0.
//  clr_idx width: $clog2(NUM_REGS), min 1; no wrap past NUM_REGS-1.
// CONFIGURATION
//  Macro REGFILE_BYPASS_EN.
//  Defined: bypass for each read port k not forced to 0 by the read rules:
//   - raddr_k matches an enabled, legal write this cycle -> rdata_k = that wdata; port 1 wins over port 0.
//   - No match -> stored value.
//   - Gives zero-latency write-to-read forwarding for the posedge write.
//  Undefined: rdata_k always shows the stored value. The write becomes visible the cycle after the posedge that performs it. Hazard cover is the forwarding unit's responsibility.
// TESTING
//  T1 reset: rst=0 with re=all-1, any raddr -> every rdata=0; release, read r5 -> 0.
//  T2 write/priority: we0=we1=1, waddr0=waddr1=7, wdata0=0x11111111, wdata1=0x22222222; next cycle read r7 -> 0x22222222.
//  T3 zero reg (ZERO_REG=1): we0=1, waddr0=0, wdata0=0xDEADBEEF; read r0 on all ports -> 0 in all cycles.
//  T4 bypass: write r3=0xA5A5A5A5 and read r3 in the same cycle.
//   - REGFILE_BYPASS_EN defined -> rdata=0xA5A5A5A5 that cycle.
//   - Undefined -> old r3 value that cycle, 0xA5A5A5A5 next cycle.
//  T5 soft clear: fill r1..r31 with nonzero values; pulse clr_req.
//   - clr_busy=1 for exactly 32 cycles; reads return 0 during clear.
//   - we0=1 to r9 mid-clear is dropped.
//   - After clear, all registers read 0.
//   - Second clr_req mid-clear does not extend clr_busy.
//  T6 reset mid-clear: assert rst=0 at clear cycle 10 -> clr_busy=0 immediately; after release, FSM is IDLE and all registers read 0.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port GPR file: N read ports, two prioritised write ports, soft-clear sequencer
// Optional same-cycle write->read forwarding enabled by REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     clr_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int CLR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0]  NREGS    = (ADDR_W+1)'(NUM_REGS);
  localparam logic [CLR_W-1:0] LAST_IDX = CLR_W'(NUM_REGS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [CLR_W-1:0]  clr_idx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok0, wr_ok1;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] val;

  // Legal register address: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok0   = (state_q == IDLE) && we0 && addr_ok(waddr0);
  assign wr_ok1   = (state_q == IDLE) && we1 && addr_ok(waddr1);
  assign clr_busy = (state_q == CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req) state_d = CLEAR;
      CLEAR:   if (clr_idx == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_idx <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state_q == CLEAR) begin
      regs[clr_idx] <= '0;
      clr_idx       <= (clr_idx == LAST_IDX) ? '0 : clr_idx + CLR_W'(1);
    end else begin
      // Port 1 is assigned last so it wins on an address collision.
      if (wr_ok0) regs[waddr0] <= wdata0;
      if (wr_ok1) regs[waddr1] <= wdata1;
      if (clr_req) clr_idx <= '0;
    end
  end

  always_comb begin
    rdata = '0;
    ra    = '0;
    val   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra  = raddr[k*ADDR_W +: ADDR_W];
      val = regs[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok0 && (waddr0 == ra)) val = wdata0;
      if (wr_ok1 && (waddr1 == ra)) val = wdata1;
`else
`endif
      if (re[k] && rst && !clr_busy && addr_ok(ra))
        rdata[k*DATA_W +: DATA_W] = val;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed table-driven bench for regfile_mp
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        clr_busy;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  int checks   = 0;
  int failures = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we0;  logic [4:0] wa0; logic [31:0] wd0;
    logic        we1;  logic [4:0] wa1; logic [31:0] wd1;
    logic [1:0]  re;   logic [4:0] ra0; logic [4:0]  ra1;
    logic [31:0] exp0; logic [31:0] exp1;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; clr_req = 0;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 1; i < 32; i++) begin
      we0 = 1; waddr0 = 5'(i); wdata0 = base + 32'(i);
      tick();
    end
    we0 = 0;
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 32; i += 2) begin
      re = 2'b11; raddr = {5'(i + 1), 5'(i)};
      @(negedge clk);
      check(name, rdata[31:0], 32'h0);
      check(name, rdata[63:32], 32'h0);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{1, 7, 32'h11111111, 1, 7, 32'h22222222, 2'b11, 5, 6, 32'h0, 32'h0};
    vecs[1] = '{0, 0, 32'h0,        0, 0, 32'h0,        2'b11, 7, 0, 32'h22222222, 32'h0};
    vecs[2] = '{1, 4, 32'h44,       1, 5, 32'h55,       2'b11, 7, 31, 32'h22222222, 32'h0};
    vecs[3] = '{1, 0, 32'hDEADBEEF, 0, 0, 32'h0,        2'b11, 4, 5, 32'h44, 32'h55};
    vecs[4] = '{0, 0, 32'h0,        0, 0, 32'h0,        2'b11, 0, 0, 32'h0, 32'h0};
    vecs[5] = '{1, 2, 32'h2,        1, 31, 32'hFFFF0000, 2'b01, 4, 5, 32'h44, 32'h0};
    vecs[6] = '{1, 4, 32'hABCD,     1, 4, 32'h0,        2'b11, 31, 2, 32'hFFFF0000, 32'h2};
    vecs[7] = '{0, 0, 32'h0,        0, 0, 32'h0,        2'b10, 4, 7, 32'h0, 32'h22222222};
    vecs[8] = '{0, 0, 32'h0,        0, 0, 32'h0,        2'b11, 0, 4, 32'h0, 32'h0};

    idle_inputs();
    rst = 0; re = 2'b11; raddr = {5'd5, 5'd7};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdata0", rdata[31:0], 32'h0);
    check("reset_rdata1", rdata[63:32], 32'h0);
    check("reset_busy", {31'h0, clr_busy}, 32'h0);
    tick();
    rst = 1;
    re = 2'b01; raddr = {5'd0, 5'd5};
    @(negedge clk);
    check("post_reset_r5", rdata[31:0], 32'h0);

    for (int v = 0; v < 9; v++) begin
      tick();
      we0 = vecs[v].we0; waddr0 = vecs[v].wa0; wdata0 = vecs[v].wd0;
      we1 = vecs[v].we1; waddr1 = vecs[v].wa1; wdata1 = vecs[v].wd1;
      re = vecs[v].re; raddr = {vecs[v].ra1, vecs[v].ra0};
      @(negedge clk);
      check($sformatf("vec%0d_port0", v), rdata[31:0], vecs[v].exp0);
      check($sformatf("vec%0d_port1", v), rdata[63:32], vecs[v].exp1);
    end

    tick();
    idle_inputs();
    we0 = 1; waddr0 = 3; wdata0 = 32'hA5A5A5A5;
    re = 2'b11; raddr = {5'd0, 5'd3};
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", rdata[31:0], 32'hA5A5A5A5);
`else
    check("bypass_same_cycle", rdata[31:0], 32'h0);
`endif
    tick();
    we0 = 0;
    @(negedge clk);
    check("bypass_next_cycle", rdata[31:0], 32'hA5A5A5A5);

    tick();
    fill(32'h01000000);
    re = 2'b11; raddr = {5'd31, 5'd9};
    @(negedge clk);
    check("fill_r9", rdata[31:0], 32'h01000009);
    check("fill_r31", rdata[63:32], 32'h0100001F);

    tick();
    clr_req = 1;
    tick();
    clr_req = 0;
    n = 0;
    while (clr_busy && n < 100) begin
      if (n == 20) begin we0 = 1; waddr0 = 9; wdata0 = 32'h99999999; end
      if (n == 25) clr_req = 1;
      if (n == 3 || n == 20) begin
        @(negedge clk);
        check("read_during_clear", rdata[31:0], 32'h0);
      end
      tick();
      we0 = 0; clr_req = 0;
      n++;
    end
    check("clear_busy_cycles", 32'(n), 32'd32);
    read_all_zero("after_clear");

    tick();
    fill(32'h02000000);
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (10) tick();
    check("busy_before_reset", {31'h0, clr_busy}, 32'h1);
    rst = 0;
    #1;
    check("busy_in_reset", {31'h0, clr_busy}, 32'h0);
    tick();
    rst = 1;
    @(negedge clk);
    check("busy_after_reset", {31'h0, clr_busy}, 32'h0);
    read_all_zero("after_reset_mid_clear");

    tick();
    we0 = 1; waddr0 = 12; wdata0 = 32'h12121212;
    tick();
    we0 = 0; re = 2'b01; raddr = {5'd0, 5'd12};
    @(negedge clk);
    check("write_after_reset", rdata[31:0], 32'h12121212);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
